// File: rtl/serial_seq_tx_if.sv
// Handshake and serial-output bundle for serial_seq_tx.
// Signals:
//   start, pattern, repeat_cnt, abort : request side (driven by the master)
//   ready, busy, x_out, x_valid, done : status and serial stream (driven by the transmitter)
// Modports: master (request source), slave (the transmitter).
interface serial_seq_tx_if #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned REP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] repeat_cnt;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             x_out;
  logic             x_valid;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, abort,
    input  ready, busy, x_out, x_valid, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, abort,
    output ready, busy, x_out, x_valid, done
  );
endinterface

// File: rtl/serial_seq_tx.sv
// Serial sequence transmitter: latches a parallel pattern and shifts it out
// MSB-first on x_out, one bit per clock, repeating it repeat_cnt+1 times with
// no gap between repetitions. Feeds the X input of the sequence detectors.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : serial_seq_tx_if.slave (start/pattern/repeat_cnt/abort in,
//           ready/busy/x_out/x_valid/done out, all outputs registered)
// Optional build macro: SEQ_TX_PARITY_EN -- appends an even-parity bit after
// the data bits of every repetition.
module serial_seq_tx #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned REP_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_seq_tx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(PAT_W);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state;
  logic [PAT_W-1:0] shreg;
  logic [PAT_W-1:0] pat_lat;
  logic [CNT_W-1:0] bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             ready;
  logic             busy;
  logic             x_out;
  logic             x_valid;
  logic             done;

  // x_out is registered from the bit that becomes the shift-register MSB,
  // so the first bit appears in the cycle right after the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      pat_lat <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort beats a simultaneous start
          if (bus.start && !bus.abort) begin
            state   <= SHIFT;
            shreg   <= bus.pattern;
            pat_lat <= bus.pattern;
            rep_cnt <= bus.repeat_cnt;
            bit_cnt <= CNT_W'(PAT_W - 1);
            x_out   <= bus.pattern[PAT_W-1];
            x_valid <= 1'b1;
            busy    <= 1'b1;
            ready   <= 1'b0;
          end
        end

`ifdef SEQ_TX_PARITY_EN
        SHIFT, PAR: begin
`else
        SHIFT: begin
`endif
          if (bus.abort) begin
            state   <= IDLE;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
          end else if (state == SHIFT && bit_cnt != '0) begin
            shreg   <= {shreg[PAT_W-2:0], 1'b0};
            x_out   <= shreg[PAT_W-2];
            bit_cnt <= bit_cnt - CNT_W'(1);
`ifdef SEQ_TX_PARITY_EN
          end else if (state == SHIFT) begin
            // reduction XOR gives the bit that makes the ones count even
            state <= PAR;
            x_out <= ^pat_lat;
`endif
          end else if (rep_cnt != '0) begin
            // back-to-back repetition: reload without an idle cycle
            state   <= SHIFT;
            rep_cnt <= rep_cnt - REP_W'(1);
            shreg   <= pat_lat;
            bit_cnt <= CNT_W'(PAT_W - 1);
            x_out   <= pat_lat[PAT_W-1];
          end else begin
            state   <= DONE;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          x_out   <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready   = ready;
  assign bus.busy    = busy;
  assign bus.x_out   = x_out;
  assign bus.x_valid = x_valid;
  assign bus.done    = done;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Directed self-checking bench for serial_seq_tx (PAT_W=8, REP_W=4).
module tb_serial_seq_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  serial_seq_tx_if #(.PAT_W(8), .REP_W(4)) bus ();

  serial_seq_tx #(.PAT_W(8), .REP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"},   bus.ready,   1'b1);
    chk({tag, ".busy"},    bus.busy,    1'b0);
    chk({tag, ".x_valid"}, bus.x_valid, 1'b0);
    chk({tag, ".x_out"},   bus.x_out,   1'b0);
    chk({tag, ".done"},    bus.done,    1'b0);
  endtask

  // Accept at edge 0, check every valid cycle, the done cycle and ready return.
  // Optional start pulses during transmission must be ignored.
  task automatic run_send(input string tag, input logic [7:0] pat,
                          input logic [3:0] rep, input bit poke);
    int   n;
    int   k;
    logic e;
    bus.start      = 1'b1;
    bus.pattern    = pat;
    bus.repeat_cnt = rep;
    tick();
    bus.start      = 1'b0;
    bus.pattern    = ~pat;
    bus.repeat_cnt = 4'hF;
    n = L * (int'(rep) + 1);
    for (int c = 0; c < n; c++) begin
      k = c % L;
      if (k < 8) e = pat[7-k];
      else       e = ^pat;
      chk({tag, ".x_valid"}, bus.x_valid, 1'b1);
      chk({tag, ".x_out"},   bus.x_out,   e);
      chk({tag, ".busy"},    bus.busy,    1'b1);
      chk({tag, ".ready"},   bus.ready,   1'b0);
      chk({tag, ".done"},    bus.done,    1'b0);
      bus.start = poke && (c % 4 == 1);
      tick();
    end
    bus.start = 1'b0;
    chk({tag, ".done_pulse"},  bus.done,    1'b1);
    chk({tag, ".done_valid"},  bus.x_valid, 1'b0);
    chk({tag, ".done_xout"},   bus.x_out,   1'b0);
    chk({tag, ".done_busy"},   bus.busy,    1'b0);
    chk({tag, ".done_ready"},  bus.ready,   1'b0);
    tick();
    chk_idle({tag, ".after"});
  endtask

  initial begin
    logic [7:0] exp_b2;
    compared       = 0;
    mismatched     = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b1;
    bus.abort      = 1'b0;
    bus.pattern    = 8'hAA;
    bus.repeat_cnt = 4'h0;

    // reset overrides start
    tick();
    tick();
    chk_idle("reset");
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk_idle("idle");

    // single send B2: hand bits 1,0,1,1,0,0,1,0
    exp_b2 = 8'b1011_0010;
    run_send("b2", exp_b2, 4'd0, 1'b0);

    // three back-to-back repetitions with ignored start pulses
    run_send("a5x3", 8'hA5, 4'd2, 1'b1);

    // abort at the edge ending cycle 5
    bus.start      = 1'b1;
    bus.pattern    = 8'hFF;
    bus.repeat_cnt = 4'd1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk("abort.pre_valid", bus.x_valid, 1'b1);
      chk("abort.pre_xout",  bus.x_out,   1'b1);
      if (c < 5) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("abort.c6");
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("abort.no_done", bus.done,    1'b0);
      chk("abort.quiet",   bus.x_valid, 1'b0);
    end
    run_send("post_abort", 8'h3C, 4'd0, 1'b0);

    // start and abort together in idle: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_idle("start_abort");

    // reset at the edge ending cycle 3
    bus.start      = 1'b1;
    bus.pattern    = 8'h5A;
    bus.repeat_cnt = 4'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("rst_mid.busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle("rst_mid");
    tick();
    chk("rst_mid.no_done", bus.done, 1'b0);
    run_send("one", 8'h01, 4'd0, 1'b0);

    // abort in idle has no effect
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("abort_idle");

`ifdef SEQ_TX_PARITY_EN
    run_send("par_b3", 8'hB3, 4'd1, 1'b0);
    bus.start      = 1'b1;
    bus.pattern    = 8'hB2;
    bus.repeat_cnt = 4'd0;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    chk("par_b2.valid", bus.x_valid, 1'b1);
    chk("par_b2.bit",   bus.x_out,   1'b0);
    tick();
    chk("par_b2.done",  bus.done,    1'b1);
    tick();
    chk("par_b3.bit_hand", 1'b1, ^(8'hB3)) ;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_seq_tx.md
Name: serial_seq_tx

Overview:
- Serial sequence transmitter. Loads a parallel bit pattern and shifts it out MSB-first, one bit per clock, on a single serial line x_out.
- Repeats the pattern a programmable number of times.
- Is the source end of the serial-sequence path: x_out drives the X input of the team's sequence-detector circuits, so lab benches can generate detector stimulus on-chip.

Parameters:
- PAT_W, 8, pattern width in bits (legal 2..32).
- REP_W, 4, width of the repeat-count input.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request to transmit; accepted only while ready=1.
- pattern  input  PAT_W  bit pattern, sampled in the accept cycle.
- repeat_cnt  input  REP_W  extra repetitions, sampled in the accept cycle; 0 = send once, N = send N+1 times.
- abort  input  1  cancels an active transmission.
- ready  output  1  block idle, start will be accepted.
- busy  output  1  transmission in progress.
- x_out  output  1  serial data bit; 0 whenever x_valid=0.
- x_valid  output  1  x_out carries a pattern (or parity) bit this cycle.
- done  output  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- One clock; reset is synchronous and active-low: clk, rst_n.
- Reset (rst_n=0 at an edge):
  - state=IDLE, ready=1, busy=0, x_out=0, x_valid=0, done=0.
  - Shift register, bit counter and repeat counter cleared.
  - Reset mid-transmission discards everything; no done pulse.
- States: IDLE, SHIFT, PAR (only with the optional feature), DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge: latch pattern into the shift register, latch repeat_cnt, bit counter=PAT_W-1, go to SHIFT.
  - Accept latency: first bit is on x_out in the cycle immediately after the accepting edge.
- SHIFT:
  - x_valid=1, busy=1, ready=0.
  - x_out = shift register MSB.
  - Each edge: shift left by 1, decrement the bit counter.
- End of pattern (bit counter reaches 0 at an edge):
  - Go to PAR if parity is enabled.
  - Otherwise, if the repeat counter is nonzero: decrement it, reload the latched pattern, bit counter=PAT_W-1, stay in SHIFT. There is no idle gap between repetitions; bit PAT_W-1 of repetition k+1 directly follows bit 0 of repetition k.
  - Otherwise go to DONE.
- DONE:
  - One cycle; done=1, x_valid=0, x_out=0, busy=0, ready=0.
  - Next edge: IDLE.
- Total schedule: accept at edge 0; valid bits in cycles 1..L*(R+1), where L=PAT_W (+1 with parity) and R=latched repeat_cnt. done is high in cycle L*(R+1)+1; ready returns in cycle L*(R+1)+2.
- start during SHIFT/PAR/DONE: ignored, not queued.
- abort=1 at an edge in SHIFT/PAR: go to IDLE; x_valid=0 next cycle, no done pulse.
- abort in IDLE or DONE: no effect. start and abort together in IDLE: abort wins, start is not accepted.
- rst_n=0 overrides abort and start.
- Pattern and repeat_cnt inputs may change freely after acceptance; only the latched copies are used.
- The repeat counter saturates at zero and never wraps.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined:
  - After the PAT_W data bits of every repetition, state PAR emits one extra bit with x_valid=1.
  - That bit makes the count of ones over the data bits plus the parity bit even.
  - Then PAR follows the same repeat/DONE decision as the end of SHIFT. L=PAT_W+1.
- Undefined: the PAR state and parity logic are absent; L=PAT_W.

Test Plan:
- Reset then idle: rst_n=0 for 2 edges, then 1 -> ready=1, busy=0, x_valid=0, x_out=0, done=0.
- Single send, PAT_W=8: start=1 with pattern=8'hB2, repeat_cnt=0 -> cycles 1..8 x_out=1,0,1,1,0,0,1,0 with x_valid=1; done=1 only in cycle 9; ready=1 in cycle 10.
- Repeat with no gap: pattern=8'hA5, repeat_cnt=2 -> 24 consecutive valid bits 10100101 x3; done in cycle 25; start pulses during the transmission are ignored.
- Abort: pattern=8'hFF, repeat_cnt=1, abort=1 at the edge ending cycle 5 -> x_valid=0 from cycle 6, no done pulse, ready=1 from cycle 6; a new start then sends normally.
- Reset mid-operation: rst_n=0 at the edge ending cycle 3 of a send -> x_valid=0, ready=1, counters cleared; the next start=1 with 8'h01 emits 0000_0001 exactly.
- SEQ_TX_PARITY_EN defined: pattern=8'hB3, repeat_cnt=1 -> 10110011 then parity 1, twice (18 valid bits); done in cycle 19. With 8'hB2 the parity bit is 0.
